// File: rtl/demux_scan_ctrl.sv
// Scan sequencer driving a 1-to-8 demux: walks the enabled channels in
// ascending order, holding each pattern bit on its channel for dwell+1 cycles.
module demux_scan_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic [7:0]         in_mask,
  input  logic [DWELL_W-1:0] in_dwell,
  input  logic               abort,
  output logic               d,
  output logic [2:0]         sel,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [7:0]         data_q;
  logic [7:0]         mask_q;
  logic [3:0]         first_ch;
  logic [3:0]         next_ch;

  // Lowest set mask bit at or above 'from'; MSB of the result flags a hit.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input int from);
    find_ch = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= from)) find_ch = {1'b1, 3'(i)};
    end
  endfunction

  always_comb begin
    first_ch = find_ch(in_mask, 0);
    next_ch  = find_ch(mask_q, int'(sel) + 1);
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      d       <= 1'b0;
      sel     <= 3'd0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      dwell_q <= '0;
      data_q  <= 8'd0;
      mask_q  <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            mask_q  <= in_mask;
            dwell_q <= in_dwell;
            if (first_ch[3]) begin
              state  <= SCAN;
              sel    <= first_ch[2:0];
              d      <= in_data[first_ch[2:0]];
              enable <= 1'b1;
              busy   <= 1'b1;
              cnt    <= in_dwell;
            end else begin
              // Empty mask completes immediately without touching the demux.
              done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            state  <= IDLE;
            enable <= 1'b0;
            d      <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (next_ch[3]) begin
            sel <= next_ch[2:0];
            d   <= data_q[next_ch[2:0]];
            cnt <= dwell_q;
          end else begin
            state  <= IDLE;
            enable <= 1'b0;
            d      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Randomized bench for demux_scan_ctrl: each command is expanded into an
// expected per-cycle output trace and compared cycle by cycle.
module tb_demux_scan_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'd0;
  logic [7:0]    in_mask = 8'd0;
  logic [DW-1:0] in_dwell = '0;
  logic          abort = 1'b0;
  logic          d;
  logic [2:0]    sel;
  logic          enable;
  logic          busy;
  logic          done;

  demux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_dwell(in_dwell), .abort(abort),
    .d(d), .sel(sel), .enable(enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [2:0] sel;
    logic       d;
    logic       busy;
    logic       done;
  } exp_t;

  int total = 0;
  int bad = 0;
  logic [2:0] exp_sel = 3'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e, input logic rdy);
    check({tag, ".enable"}, 32'(enable), 32'(e.en));
    check({tag, ".sel"}, 32'(sel), 32'(e.sel));
    check({tag, ".d"}, 32'(d), 32'(e.d));
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({tag, ".done"}, 32'(done), 32'(e.done));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with random abort noise, which IDLE must ignore.
  task automatic idle(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      abort = 1'(($urandom & 1));
      tick();
      e = '{en: 1'b0, sel: exp_sel, d: 1'b0, busy: 1'b0, done: 1'b0};
      check_out("idle", e, 1'b1);
    end
    abort = 1'b0;
  endtask

  // Entered and left at #1 after an edge; leaves the bench in the cycle after
  // the scan, so the next command lands back-to-back.
  task automatic run_cmd(input logic [7:0] data, input logic [7:0] mask,
                         input logic [DW-1:0] dwell, input int abort_at);
    exp_t q[$];
    exp_t e;
    logic aborted;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        for (int r = 0; r <= int'(dwell); r++) begin
          q.push_back('{en: 1'b1, sel: 3'(i), d: data[i], busy: 1'b1, done: 1'b0});
        end
      end
    end
    aborted = (abort_at >= 0) && (abort_at < q.size());
    if (aborted) q = q[0:abort_at];
    if (q.size() > 0) exp_sel = q[$].sel;
    q.push_back('{en: 1'b0, sel: exp_sel, d: 1'b0, busy: 1'b0, done: !aborted});

    check("accept.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_mask  = mask;
    in_dwell = dwell;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_mask  = 8'($urandom);
    in_dwell = DW'($urandom);
    for (int j = 0; j < q.size(); j++) begin
      check_out(aborted ? "scan_abort" : "scan", q[j], (j == q.size() - 1));
      if (j < q.size() - 1) begin
        abort = (j == abort_at);
        tick();
        abort = 1'b0;
      end
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    e = '{en: 1'b0, sel: 3'd0, d: 1'b0, busy: 1'b0, done: 1'b0};
    check_out("in_reset", e, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    idle(5);

    run_cmd(8'hA5, 8'hFF, DW'(0), -1);
    idle(1);
    run_cmd(8'hFF, 8'h81, DW'(2), -1);
    idle(2);
    run_cmd(8'h3C, 8'h00, DW'(5), -1);
    idle(1);
    // abort in the 2nd cycle of channel 2, then an immediate new command
    run_cmd(8'h5A, 8'hFF, DW'(3), 9);
    run_cmd(8'hC3, 8'h24, DW'(1), -1);
    // back-to-back: next command presented in the done cycle
    run_cmd(8'h96, 8'h11, DW'(255), -1);
    run_cmd(8'h0F, 8'h80, DW'(0), -1);
    run_cmd(8'hFF, 8'h00, DW'(0), -1);
    run_cmd(8'hAA, 8'hF0, DW'(1), 0);
    idle(2);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] m;
      int ab;
      m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_cmd(8'($urandom), m, DW'($urandom_range(0, 3)), ab);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end

    // reset mid-scan
    run_cmd(8'hFF, 8'hFF, DW'(0), -1);
    idle(1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_mask  = 8'hFC;
    in_dwell = DW'(3);
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_reset.enable", 32'(enable), 32'd1);
    check("pre_reset.sel", 32'(sel), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{en: 1'b0, sel: 3'd0, d: 1'b0, busy: 1'b0, done: 1'b0};
    check_out("async_reset", e, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_sel = 3'd0;
    #4;
    idle(3);
    run_cmd(8'h81, 8'h81, DW'(1), -1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
# demux_scan_ctrl

Sequencer that sits directly upstream of the 1-to-8 demultiplexer and drives its `d`, `sel` and `enable` inputs. It accepts one 8-bit pattern, with a channel mask and dwell time, per valid/ready handshake. It then scans the enabled channels in ascending order, presenting each pattern bit on its channel for a programmable number of cycles. A one-cycle `done` pulse marks the end of each scan, and an `abort` input cancels a scan in progress.

## Interface
- `DWELL_W`, default 8: width of the dwell field; each channel is held for `dwell+1` cycles.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: command valid.
- `in_ready`  out  1: command ready; combinational, equals (state == IDLE).
- `in_data`  in  8: pattern; bit i is driven on channel i.
- `in_mask`  in  8: channel mask; bit i = 1 means channel i is visited.
- `in_dwell`  in  DWELL_W: hold count per channel, minus one.
- `abort`  in  1: cancel the scan in progress.
- `d`  out  1: demux data input, registered.
- `sel`  out  3: demux select, registered.
- `enable`  out  1: demux enable, registered.
- `busy`  out  1: high while state == SCAN, registered.
- `done`  out  1: one-cycle pulse when a scan completes normally, registered.

## Operation
- Reset values (async, while `rst_n` = 0): state = IDLE, `d` = 0, `sel` = 0, `enable` = 0, `busy` = 0, `done` = 0, internal dwell counter = 0. `in_ready` reads 1 once the flops reset.
- States are IDLE and SCAN.
- IDLE:
  - `enable` = 0 and `d` = 0.
  - `sel` holds its last value.
  - Accept occurs when `in_valid` && `in_ready` at a rising edge; it latches `in_data`, `in_mask` and `in_dwell`.
- On accept with `in_mask` != 0:
  - Go to SCAN.
  - `sel` = lowest set mask bit, `d` = `in_data`[sel], `enable` = 1, `busy` = 1.
  - Dwell counter loads `in_dwell`.
- On accept with `in_mask` == 0:
  - Stay in IDLE and pulse `done` the next cycle.
  - `enable` never asserts.
- SCAN:
  - Each cycle, the counter decrements while nonzero.
  - When the counter is 0 and a higher masked channel exists, `sel` jumps straight to the next set mask bit (masked-off channels take zero cycles). `d` follows the pattern, the counter reloads the dwell, and `enable` stays 1 with no gap.
  - When the counter is 0 and no higher masked channel exists, go to IDLE. That cycle: `enable` = 0, `d` = 0, `busy` = 0, `done` = 1.
- Abort:
  - `abort` = 1 in SCAN: next cycle is IDLE with `enable` = 0, `d` = 0, `busy` = 0, and `done` stays 0.
  - `abort` is ignored in IDLE.
  - `abort` takes priority over a channel advance or completion in the same cycle.
- Commands are not accepted during SCAN (`in_ready` = 0). A command presented in the completion cycle (`done` = 1, state IDLE) is accepted, giving back-to-back scans with exactly one `enable` = 0 cycle between them.
- Reset mid-scan: outputs go to their reset values immediately, with no `done` pulse.

## Timing
- Accept at edge T: `enable` = 1 from T+1.
- Per channel: `dwell`+1 cycles with `enable` = 1.
- Total scan: popcount(mask) × (`dwell`+1) cycles with `enable` high, then a `done` pulse in the following cycle.
- `d` and `sel` change only at channel boundaries and are stable whenever `enable` = 1.
- `in_ready` is high in the `done` cycle.
- Max `dwell` = 2^DWELL_W − 1. The counter does not wrap: a reload happens only at 0.

## Test plan
- Reset release, then idle for 5 cycles: `enable` = `d` = `busy` = `done` = 0, `sel` = 0, `in_ready` = 1.
- `data` = 0xA5, `mask` = 0xFF, `dwell` = 0:
  - `sel` steps 0..7 on consecutive cycles; `d` sequence is 1,0,1,0,0,1,0,1.
  - `done` fires 9 cycles after accept (cycle T+9).
- `data` = 0xFF, `mask` = 0x81, `dwell` = 2:
  - `sel` = 0 for 3 cycles, then `sel` = 7 for 3 cycles.
  - `done` fires at T+7.
- `mask` = 0x00:
  - No `enable` cycle; `done` = 1 at T+1; `busy` stays 0.
- `mask` = 0xFF, `dwell` = 3, `abort` during the 2nd cycle of channel 2:
  - `enable` = 0 the next cycle; no `done` pulse.
  - A new command is accepted immediately after.
- Back-to-back scans with `in_valid` held high, and a separate reset mid-scan:
  - Back-to-back: the 2nd scan is accepted in the `done` cycle, with exactly one `enable` = 0 gap between scans.
  - Reset mid-scan: `enable` drops asynchronously and all outputs return to their reset values.
